// File: rtl/eth_irq_coalescer_pkg.sv
// Shared types and constants for the Ethernet interrupt coalescer.
// Holds the FSM state encoding, cause bit positions and config reset values.
package eth_irq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2,
        GAP   = 2'd3
    } coal_state_e;

    localparam int unsigned CAUSE_RX = 0;
    localparam int unsigned CAUSE_TX = 1;

    localparam int unsigned THRESH_RST  = 1;
    localparam int unsigned TIMEOUT_RST = 0;
    localparam int unsigned GAP_RST     = 0;

endpackage

// File: rtl/eth_irq_coalescer_if.sv
// Bundle of the Ethernet core's pending/event signals, CSR config strobes
// and the coalesced interrupt outputs.
interface eth_irq_coalescer_if #(
    parameter int unsigned cnt_width_p   = 8,
    parameter int unsigned timer_width_p = 16
);
    logic                     en_i;
    logic                     rx_pending_i;
    logic                     tx_pending_i;
    logic                     rx_event_i;
    logic                     tx_event_i;
    logic [cnt_width_p-1:0]   thresh_i;
    logic                     thresh_v_i;
    logic [timer_width_p-1:0] timeout_i;
    logic                     timeout_v_i;
    logic [timer_width_p-1:0] gap_i;
    logic                     gap_v_i;
    logic                     irq_ack_i;
    logic                     irq_o;
    logic [1:0]               cause_o;
    logic [cnt_width_p-1:0]   event_cnt_o;

    modport master (
        output en_i, rx_pending_i, tx_pending_i, rx_event_i, tx_event_i,
        output thresh_i, thresh_v_i, timeout_i, timeout_v_i, gap_i, gap_v_i,
        output irq_ack_i,
        input  irq_o, cause_o, event_cnt_o
    );

    modport slave (
        input  en_i, rx_pending_i, tx_pending_i, rx_event_i, tx_event_i,
        input  thresh_i, thresh_v_i, timeout_i, timeout_v_i, gap_i, gap_v_i,
        input  irq_ack_i,
        output irq_o, cause_o, event_cnt_o
    );
endinterface

// File: rtl/eth_irq_coalescer_timer.sv
// Clearable, enabled up-counter with an equality match output.
// Saturates at all-ones so a long idle stretch cannot alias back into a match.
module eth_irq_coal_timer #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clr_i,
    input  logic               inc_i,
    input  logic [width_p-1:0] match_val_i,
    output logic               match_o
);
    logic [width_p-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(width_p-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign match_o = (cnt_q == match_val_i);
endmodule

// File: rtl/eth_irq_coalescer.sv
// Merges RX/TX interrupt pending into one registered irq with count-threshold
// and timeout coalescing, plus a minimum quiet gap after each acknowledge.
module eth_irq_coalescer
    import eth_irq_pkg::*;
#(
    parameter int unsigned cnt_width_p   = 8,
    parameter int unsigned timer_width_p = 16
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    eth_irq_coalescer_if.slave  bus
);
    localparam logic [cnt_width_p-1:0]   CNT_ONE = {{(cnt_width_p-1){1'b0}}, 1'b1};
    localparam logic [timer_width_p-1:0] TMR_ONE = {{(timer_width_p-1){1'b0}}, 1'b1};

    coal_state_e              state_d, state_q;
    logic [cnt_width_p-1:0]   cnt_d, cnt_q;
    logic [1:0]               cause_d, cause_q;
    logic                     irq_d, irq_q;
    logic [cnt_width_p-1:0]   thresh_d, thresh_q;
    logic [timer_width_p-1:0] timeout_d, timeout_q;
    logic [timer_width_p-1:0] gap_d, gap_q;

    logic [1:0]               ev_n;
    logic [cnt_width_p-1:0]   ev_ext;
    logic [cnt_width_p:0]     cnt_sum;
    logic [cnt_width_p-1:0]   cnt_sat;
    logic [cnt_width_p-1:0]   thr_eff;
    logic                     pend;
    logic                     tmo_match, gap_match;
    logic                     do_exit;
    logic [cnt_width_p-1:0]   exit_cnt;

    assign pend    = bus.rx_pending_i | bus.tx_pending_i;
    assign ev_n    = {1'b0, bus.rx_event_i} + {1'b0, bus.tx_event_i};
    assign ev_ext  = {{(cnt_width_p-2){1'b0}}, ev_n};
    assign cnt_sum = {1'b0, cnt_q} + {{(cnt_width_p-1){1'b0}}, ev_n};
    assign cnt_sat = cnt_sum[cnt_width_p] ? '1 : cnt_sum[cnt_width_p-1:0];
    assign thr_eff = (thresh_q == '0) ? CNT_ONE : thresh_q;

    // Timers sit at zero outside their state, so entering the state starts them from 0.
    eth_irq_coal_timer #(.width_p(timer_width_p)) u_tmo_timer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clr_i       (!bus.en_i || (state_q != ACCUM)),
        .inc_i       (state_q == ACCUM),
        .match_val_i (timeout_q - TMR_ONE),
        .match_o     (tmo_match)
    );

    eth_irq_coal_timer #(.width_p(timer_width_p)) u_gap_timer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clr_i       (!bus.en_i || (state_q != GAP)),
        .inc_i       (state_q == GAP),
        .match_val_i (gap_q - TMR_ONE),
        .match_o     (gap_match)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        thresh_d  = bus.thresh_v_i  ? bus.thresh_i  : thresh_q;
        timeout_d = bus.timeout_v_i ? bus.timeout_i : timeout_q;
        gap_d     = bus.gap_v_i     ? bus.gap_i     : gap_q;
        do_exit   = 1'b0;
        exit_cnt  = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ev_n != 2'd0) begin
                    cnt_d   = ev_ext;
                    state_d = (ev_ext >= thr_eff) ? FIRE : ACCUM;
                end
            end
            ACCUM: begin
                if (!pend) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_sat;
                    if ((cnt_sat >= thr_eff) || ((timeout_q != '0) && tmo_match))
                        state_d = FIRE;
                end
            end
            FIRE: begin
                cnt_d = cnt_sat;
                if (bus.irq_ack_i || !pend) begin
                    // Events landing on the ack cycle seed the next batch.
                    cnt_d = ev_ext;
                    if (gap_q != '0) begin
                        state_d = GAP;
                    end else begin
                        do_exit  = 1'b1;
                        exit_cnt = ev_ext;
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_sat;
                if ((gap_q == '0) || gap_match) begin
                    do_exit  = 1'b1;
                    exit_cnt = cnt_sat;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (do_exit) begin
            if (pend && (exit_cnt >= thr_eff)) begin
                state_d = FIRE;
                cnt_d   = exit_cnt;
            end else if (pend && (exit_cnt != '0)) begin
                state_d = ACCUM;
                cnt_d   = exit_cnt;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end

        if (!bus.en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // Cause is latched only on a fresh rise, including an immediate re-fire.
        if ((state_d == FIRE) && ((state_q != FIRE) || do_exit)) begin
            cause_d[CAUSE_TX] = bus.tx_pending_i;
            cause_d[CAUSE_RX] = bus.rx_pending_i;
        end

        irq_d = (state_d == FIRE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            irq_q     <= 1'b0;
            thresh_q  <= cnt_width_p'(THRESH_RST);
            timeout_q <= timer_width_p'(TIMEOUT_RST);
            gap_q     <= timer_width_p'(GAP_RST);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            irq_q     <= irq_d;
            thresh_q  <= thresh_d;
            timeout_q <= timeout_d;
            gap_q     <= gap_d;
        end
    end

    assign bus.irq_o       = irq_q;
    assign bus.cause_o     = cause_q;
    assign bus.event_cnt_o = cnt_q;
endmodule

// File: tb/tb_eth_irq_coalescer.sv
// Directed bench for eth_irq_coalescer: a per-cycle vector table followed by
// hand-written sequences for timeout, gap, enable, saturation and async reset.
module tb_eth_irq_coalescer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    eth_irq_coalescer_if #(.cnt_width_p(8), .timer_width_p(16)) bus ();

    eth_irq_coalescer #(.cnt_width_p(8), .timer_width_p(16)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en, rxp, txp, rxe, txe, ack, thv;
        logic [7:0] th;
        logic       irq;
        logic [1:0] cause;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, logic rxp, logic txp, logic rxe, logic txe,
                                logic ack, logic thv, logic [7:0] th,
                                logic irq, logic [1:0] cause, logic [7:0] cnt);
        vec_t v;
        v.en = en; v.rxp = rxp; v.txp = txp; v.rxe = rxe; v.txe = txe;
        v.ack = ack; v.thv = thv; v.th = th;
        v.irq = irq; v.cause = cause; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rxp, input logic txp,
                         input logic rxe, input logic txe, input logic ack);
        bus.en_i = en; bus.rx_pending_i = rxp; bus.tx_pending_i = txp;
        bus.rx_event_i = rxe; bus.tx_event_i = txe; bus.irq_ack_i = ack;
        bus.thresh_v_i = 1'b0; bus.timeout_v_i = 1'b0; bus.gap_v_i = 1'b0;
    endtask

    task automatic cfg(input logic thv, input logic [7:0] th,
                       input logic tov, input logic [15:0] to,
                       input logic gv, input logic [15:0] g);
        bus.thresh_v_i = thv;  bus.thresh_i  = th;
        bus.timeout_v_i = tov; bus.timeout_i = to;
        bus.gap_v_i = gv;      bus.gap_i     = g;
    endtask

    task automatic chk_out(input string nm, input logic irq, input logic [1:0] cause,
                           input logic [7:0] cnt);
        chk({nm, ".irq"},   32'(bus.irq_o),       32'(irq));
        chk({nm, ".cause"}, 32'(bus.cause_o),     32'(cause));
        chk({nm, ".cnt"},   32'(bus.event_cnt_o), 32'(cnt));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        cfg(0, 8'd0, 0, 16'd0, 0, 16'd0);

        //          en rxp txp rxe txe ack thv th      irq cause  cnt
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'd0,  1, 2'b01, 8'd1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 8'd0,  0, 2'b01, 8'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'd4,  0, 2'b01, 8'd0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 8'd0,  0, 2'b01, 8'd1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'd0,  0, 2'b01, 8'd1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 8'd0,  0, 2'b01, 8'd2));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 8'd0,  0, 2'b01, 8'd3));
        vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 8'd0,  1, 2'b10, 8'd4));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'd0,  1, 2'b10, 8'd4));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 8'd0,  0, 2'b10, 8'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'd0,  0, 2'b10, 8'd0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 8'd0,  0, 2'b10, 8'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'd0,  0, 2'b10, 8'd0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'd0,  1, 2'b01, 8'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'd0,  0, 2'b01, 8'd0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 8'd0,  1, 2'b01, 8'd1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'd0,  0, 2'b01, 8'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'd2,  0, 2'b01, 8'd0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'd0,  1, 2'b11, 8'd2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 8'd0,  0, 2'b11, 8'd0));

        tick();
        tick();
        chk_out("reset", 0, 2'b00, 8'd0);
        rst_n = 1'b1;
        tick();
        chk_out("post_reset", 0, 2'b00, 8'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].rxp, vecs[i].txp, vecs[i].rxe, vecs[i].txe, vecs[i].ack);
            cfg(vecs[i].thv, vecs[i].th, 0, 16'd0, 0, 16'd0);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].irq, vecs[i].cause, vecs[i].cnt);
        end

        // Timeout: thresh=8, timeout=20, two events then pending held.
        drive(1, 0, 0, 0, 0, 0);
        cfg(1, 8'd8, 1, 16'd20, 0, 16'd0);
        tick();
        drive(1, 1, 0, 1, 0, 0);
        tick();
        chk_out("tmo_e0", 0, 2'b11, 8'd1);
        drive(1, 1, 0, 1, 0, 0);
        tick();
        chk_out("tmo_e1", 0, 2'b11, 8'd2);
        drive(1, 1, 0, 0, 0, 0);
        for (int k = 2; k <= 20; k++) begin
            tick();
            chk($sformatf("tmo_irq_k%0d", k), 32'(bus.irq_o), 32'(k == 20));
        end
        chk_out("tmo_fire", 1, 2'b01, 8'd2);
        drive(1, 0, 0, 0, 0, 1);
        tick();
        chk_out("tmo_ack", 0, 2'b01, 8'd0);

        // Gap: fire at thresh=1, raise thresh to 8, ack with a coincident event.
        drive(1, 0, 0, 0, 0, 0);
        cfg(1, 8'd1, 1, 16'd0, 1, 16'd10);
        tick();
        drive(1, 1, 0, 1, 0, 0);
        tick();
        chk("gap_pre_fire", 32'(bus.irq_o), 32'd1);
        drive(1, 1, 0, 0, 0, 0);
        cfg(1, 8'd8, 0, 16'd0, 0, 16'd0);
        tick();
        chk("gap_fire_hold", 32'(bus.irq_o), 32'd1);
        drive(1, 1, 0, 1, 0, 1);
        tick();
        chk_out("gap_ack", 0, 2'b01, 8'd1);
        for (int k = 1; k <= 10; k++) begin
            drive(1, 1, 0, (k <= 7), 0, 0);
            tick();
            chk($sformatf("gap_irq_k%0d", k), 32'(bus.irq_o), 32'(k == 10));
        end
        chk("gap_cnt", 32'(bus.event_cnt_o), 32'd8);

        // Disable while in GAP, then confirm IDLE by an immediate fire at thresh=1.
        drive(1, 1, 0, 0, 0, 1);
        tick();
        chk_out("dis_gap_entry", 0, 2'b01, 8'd0);
        drive(0, 1, 0, 0, 0, 0);
        cfg(1, 8'd1, 0, 16'd0, 0, 16'd0);
        tick();
        chk_out("dis_idle", 0, 2'b01, 8'd0);
        drive(1, 1, 0, 1, 0, 0);
        tick();
        chk_out("dis_refire", 1, 2'b01, 8'd1);

        // Ack into a 10-cycle gap while dropping gap to 0: gap exits at once to IDLE.
        drive(1, 0, 0, 0, 0, 1);
        cfg(1, 8'd255, 0, 16'd0, 1, 16'd0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_out("sat_idle", 0, 2'b01, 8'd0);

        // Saturation: two events per cycle against thresh=255.
        drive(1, 1, 0, 1, 1, 0);
        for (int n = 1; n <= 128; n++) begin
            tick();
            if (n == 127) chk_out("sat_127", 0, 2'b01, 8'd254);
            if (n == 128) chk_out("sat_128", 1, 2'b01, 8'd255);
        end

        // Async reset in FIRE clears outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 0, 2'b00, 8'd0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 0, 0);
        tick();
        chk_out("arst_thresh1", 1, 2'b01, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
